// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: shared types and encodings for the multi-cycle ALU.
//   state_e  - control FSM states
//   md_op_e  - operation selector for the iterative mul/div unit
//   CTRL_*   - {funct7[5], funct3} encodings of the single-cycle ops
//   MF3_*    - funct3 codes of the M-group ops
package alu_mc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MD_MUL,
    MD_DIVU,
    MD_REMU
  } md_op_e;

  localparam logic [3:0] CTRL_ADD  = 4'b0000;
  localparam logic [3:0] CTRL_SUB  = 4'b1000;
  localparam logic [3:0] CTRL_SLL  = 4'b0001;
  localparam logic [3:0] CTRL_SLT  = 4'b0010;
  localparam logic [3:0] CTRL_SLTU = 4'b0011;
  localparam logic [3:0] CTRL_XOR  = 4'b0100;
  localparam logic [3:0] CTRL_SRL  = 4'b0101;
  localparam logic [3:0] CTRL_SRA  = 4'b1101;
  localparam logic [3:0] CTRL_OR   = 4'b0110;
  localparam logic [3:0] CTRL_AND  = 4'b0111;

  localparam logic [2:0] MF3_MUL   = 3'b000;
  localparam logic [2:0] MF3_DIVU  = 3'b101;
  localparam logic [2:0] MF3_REMU  = 3'b111;

endpackage

// File: rtl/alu_mc_muldiv.sv
// alu_mc_muldiv: iterative unsigned multiply (low half, shift-add) and
// restoring divide, one bit per cycle, WIDTH iterations per op.
//   clk, rst  - clock, synchronous active-high reset
//   start     - load operands and op, begin iterating next cycle
//   op        - MD_MUL / MD_DIVU / MD_REMU
//   a, b      - operands (multiplicand/multiplier or dividend/divisor)
//   done      - high during the final iteration cycle
//   result    - value produced by the final iteration (valid with done)
module alu_mc_muldiv
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  md_op_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  // acc: running product, or partial remainder
  // x:   shifting multiplicand, or dividend shifting out / quotient shifting in
  // y:   shifting multiplier, or divisor
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH:0]   rem_sh;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
    rem_sh = {acc_q, x_q[WIDTH-1]};
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(WIDTH);
      op_d   = op;
      acc_d  = '0;
      x_d    = a;
      y_d    = b;
    end else if (busy_q) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
      end
      if (op_q == MD_MUL) begin
        if (y_q[0]) begin
          acc_d = acc_q + x_q;
        end
        x_d = {x_q[WIDTH-2:0], 1'b0};
        y_d = {1'b0, y_q[WIDTH-1:1]};
      end else begin
        // Divide by zero falls out naturally: every trial subtract of 0
        // succeeds, giving an all-ones quotient and remainder == dividend.
        if (rem_sh >= {1'b0, y_q}) begin
          acc_d = rem_sh[WIDTH-1:0] - y_q;
          x_d   = {x_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          x_d   = {x_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  // done/result look at the final iteration's next-state so the owner can
  // latch the answer on the same edge the last iteration completes.
  always_comb begin
    done   = busy_q && (cnt_q == CNT_W'(1));
    result = (op_q == MD_DIVU) ? x_d : acc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      op_q   <= MD_MUL;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: ALU with single-cycle base ops and an iterative M-group
// (mul / divu / remu). Valid/ready handshakes on both sides.
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - op handshake; in_ready only in IDLE
//   input_a, input_b    - operands
//   ctrl                - {funct7[5], funct3}
//   m_ext               - select M-group (ctrl[2:0] picks the op)
//   out_valid, out_ready- result handshake
//   out, is_zero        - result and its zero flag, held while out_valid
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [3:0]       ctrl,
  input  logic             m_ext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             is_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             md_sel;
  md_op_e           md_op;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] alu_res;
  logic [SHAMT_W-1:0] shamt;

  assign accept   = in_valid & in_ready;
  assign md_start = accept & md_sel;

  // M-group decode; unsupported M codes fall through to the inline path.
  always_comb begin
    md_sel = 1'b0;
    md_op  = MD_MUL;
    if (m_ext) begin
      unique case (ctrl[2:0])
        MF3_MUL:  begin md_sel = 1'b1; md_op = MD_MUL;  end
        MF3_DIVU: begin md_sel = 1'b1; md_op = MD_DIVU; end
        MF3_REMU: begin md_sel = 1'b1; md_op = MD_REMU; end
        default:  begin md_sel = 1'b0; md_op = MD_MUL;  end
      endcase
    end
  end

  always_comb begin
    shamt   = input_b[SHAMT_W-1:0];
    alu_res = '0;
    if (!m_ext) begin
      unique case (ctrl)
        CTRL_ADD:  alu_res = input_a + input_b;
        CTRL_SUB:  alu_res = input_a - input_b;
        CTRL_SLL:  alu_res = input_a << shamt;
        CTRL_SLT:  alu_res = WIDTH'($signed(input_a) < $signed(input_b));
        CTRL_SLTU: alu_res = WIDTH'(input_a < input_b);
        CTRL_XOR:  alu_res = input_a ^ input_b;
        CTRL_SRL:  alu_res = input_a >> shamt;
        CTRL_SRA:  alu_res = $unsigned($signed(input_a) >>> shamt);
        CTRL_OR:   alu_res = input_a | input_b;
        CTRL_AND:  alu_res = input_a & input_b;
        default:   alu_res = '0;
      endcase
    end
  end

  alu_mc_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .op    (md_op),
    .a     (input_a),
    .b     (input_b),
    .done  (md_done),
    .result(md_result)
  );

  // Next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = md_sel ? S_BUSY : S_DONE;
      S_BUSY:  if (md_done) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result capture: at accept for inline ops, at the last iteration for M ops.
  always_comb begin
    out_d  = out_q;
    zero_d = zero_q;
    if (state_q == S_IDLE && accept && !md_sel) begin
      out_d  = alu_res;
      zero_d = (alu_res == '0);
    end else if (state_q == S_BUSY && md_done) begin
      out_d  = md_result;
      zero_d = (md_result == '0);
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    out       = out_q;
    is_zero   = zero_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] input_a, input_b;
  logic [3:0]  ctrl;
  logic        m_ext;
  logic        out_valid, out_ready;
  logic [31:0] out;
  logic        is_zero;

  logic        in_valid8, in_ready8;
  logic [7:0]  input_a8, input_b8;
  logic [3:0]  ctrl8;
  logic        m_ext8;
  logic        out_valid8;
  logic        out_ready8;
  logic [7:0]  out8;
  logic        is_zero8;

  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .input_a(input_a), .input_b(input_b), .ctrl(ctrl), .m_ext(m_ext),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .is_zero(is_zero)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .input_a(input_a8), .input_b(input_b8), .ctrl(ctrl8), .m_ext(m_ext8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out(out8), .is_zero(is_zero8)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   next_stall = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model straight from the op definitions.
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c, input logic m);
    logic [63:0] p;
    int unsigned sh;
    sh = b % 32;
    if (m) begin
      if (c[2:0] == 3'd0) begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
      if (c[2:0] == 3'd5) return (b == 0) ? 32'hFFFF_FFFF : a / b;
      if (c[2:0] == 3'd7) return (b == 0) ? a : a % b;
      return 32'd0;
    end
    case (c)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << sh;
      4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a ^ b;
      4'b0101: return a >> sh;
      4'b1101: return $unsigned($signed(a) >>> sh);
      4'b0110: return a | b;
      4'b0111: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] c, input logic m);
    if (m && (c[2:0] == 3'd0 || c[2:0] == 3'd5 || c[2:0] == 3'd7)) return 33;
    return 1;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      default: return 32'($urandom);
    endcase
  endfunction

  // Waits for in_ready (driving ignored garbage meanwhile), issues one op
  // and pushes its expected result.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] c, input logic m);
    int guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 400) begin
      in_valid = 1'($urandom);
      input_a  = $urandom;
      input_b  = $urandom;
      ctrl     = 4'($urandom);
      m_ext    = 1'($urandom);
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL in_ready_timeout: got in_ready=0 after %0d cycles, expected 1", guard);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b1;
    input_a  = a;
    input_b  = b;
    ctrl     = c;
    m_ext    = m;
    e.res = ref_model(a, b, c, m);
    e.lat = lat_of(c, m);
    e.acc = cyc;
    @(posedge clk);
    #1;
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  // Consumer: random back-pressure, or a forced stall length when requested.
  initial begin : ready_drv
    int stall;
    logic pv;
    stall = 0;
    pv = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && !pv) begin
        stall = (next_stall >= 0) ? next_stall : int'($urandom_range(0, 3));
        next_stall = -1;
      end
      if (out_valid !== 1'b1) stall = 0;
      out_ready = (stall == 0);
      if (stall > 0) stall--;
      pv = (out_valid === 1'b1);
    end
  end

  // Monitor
  initial begin : monitor
    logic        pv;
    logic [31:0] held;
    logic        held_z;
    exp_t        e;
    pv = 1'b0;
    held = '0;
    held_z = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && !pv) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got out=0x%0h with no op outstanding, expected none", out);
        end else begin
          e = sb.pop_front();
          chk("result", 64'(out), 64'(e.res));
          chk("is_zero", 64'(is_zero), 64'(e.res == 32'd0));
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
        end
        held   = out;
        held_z = is_zero;
      end else if (out_valid === 1'b1) begin
        chk("hold_out", 64'(out), 64'(held));
        chk("hold_is_zero", 64'(is_zero), 64'(held_z));
      end
      if (out_valid === 1'b1) chk("in_ready_low_when_valid", 64'(in_ready), 64'(0));
      pv = (out_valid === 1'b1);
    end
  end

  logic [3:0] enc [10] = '{4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
                           4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111};
  logic [2:0] mcodes [3] = '{3'd0, 3'd5, 3'd7};

  initial begin : main
    int guard;
    int acc;
    logic [3:0] c;
    logic m;
    rst = 1'b1;
    in_valid = 1'b0; input_a = '0; input_b = '0; ctrl = '0; m_ext = 1'b0;
    in_valid8 = 1'b0; input_a8 = '0; input_b8 = '0; ctrl8 = '0; m_ext8 = 1'b0;
    out_ready8 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    chk("reset_out", 64'(out), 64'(0));
    chk("reset_is_zero", 64'(is_zero), 64'(0));

    issue(32'hFFFF_FFFF, 32'd1, 4'b0000, 1'b0);
    issue(32'd5, 32'd7, 4'b1000, 1'b0);
    issue(32'h8000_0000, 32'h21, 4'b1101, 1'b0);
    issue(32'h0001_0000, 32'h0001_0000, 4'b0000, 1'b1);
    issue(32'd100, 32'd7, 4'b0101, 1'b1);
    issue(32'd100, 32'd7, 4'b0111, 1'b1);
    next_stall = 5;
    issue(32'd9, 32'd0, 4'b0101, 1'b1);
    issue(32'd9, 32'd0, 4'b0111, 1'b1);
    issue(32'd1234, 32'd55, 4'b0010, 1'b1);
    issue(32'd1234, 32'd55, 4'b1001, 1'b0);

    // Abort a multiply mid-flight.
    issue(32'h1234_5678, 32'h9abc_def0, 4'b0000, 1'b1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (sb.size() > 0) void'(sb.pop_back());
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_out", 64'(out), 64'(0));
    issue(32'd2, 32'd3, 4'b0000, 1'b0);

    for (int i = 0; i < 200; i++) begin
      m = ($urandom_range(0, 9) < 3);
      if (m) begin
        c = 4'($urandom);
        if ($urandom_range(0, 3) != 0) c[2:0] = mcodes[$urandom_range(0, 2)];
      end else begin
        c = ($urandom_range(0, 4) != 0) ? enc[$urandom_range(0, 9)] : 4'($urandom);
      end
      issue(rnd_operand(), rnd_operand(), c, m);
    end

    guard = 0;
    while (sb.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_outstanding", 64'(sb.size()), 64'(0));
    repeat (8) @(negedge clk);

    // Narrow build: mul 15*17 and an undefined encoding.
    @(negedge clk);
    input_a8 = 8'd15; input_b8 = 8'd17; ctrl8 = 4'b0000; m_ext8 = 1'b1; in_valid8 = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (out_valid8 !== 1'b1 && guard < 30);
    chk("w8_mul_latency", 64'(cyc - acc), 64'(9));
    chk("w8_mul_out", 64'(out8), 64'(8'hFF));
    chk("w8_mul_is_zero", 64'(is_zero8), 64'(0));
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (in_ready8 !== 1'b1 && guard < 30);
    input_a8 = 8'h5A; input_b8 = 8'h33; ctrl8 = 4'b1001; m_ext8 = 1'b0; in_valid8 = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (out_valid8 !== 1'b1 && guard < 30);
    chk("w8_undef_latency", 64'(cyc - acc), 64'(1));
    chk("w8_undef_out", 64'(out8), 64'(0));
    chk("w8_undef_is_zero", 64'(is_zero8), 64'(1));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
